// File: rtl/pconv_ctrl.sv
// -----------------------------------------------------------------------------
// pconv_ctrl
//   Sequencer for one pointwise (1x1) convolution unit. For every pixel of an
//   INPUT_SIZE x INPUT_SIZE map, and for every output channel of that pixel, it:
//     - fetches the channel vector, the weight vector, the bias and the shift
//       from synchronous memories;
//     - drives the convolution unit;
//     - writes the unit result to the output feature buffer.
//   Output channel is the inner loop and pixel is the outer loop, so output
//   buffer addresses are strictly ascending.
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start           layer launch, sampled only while idle
//   busy            high from the cycle after start is accepted until done
//   done            single-cycle pulse after the last result is written
//   pix_addr        input map RAM address (pixel index)
//   pix_din         input map RAM data, one-cycle read latency
//   w_addr          weight/bias/shift ROM address (output channel)
//   w_din           weight ROM data, one-cycle read latency
//   bias_din        bias ROM data, one-cycle read latency
//   shift_din       shift ROM data, one-cycle read latency
//   u_ce            unit clock enable
//   u_input_vld     unit operand strobe (one cycle per result)
//   u_input_din     registered pixel vector to the unit
//   u_weight_din    registered weight vector to the unit
//   u_bias          registered bias to the unit
//   u_shift         registered shift to the unit
//   u_dout          unit result
//   u_dout_vld      unit result valid
//   out_we          output buffer write strobe (single-cycle pulse)
//   out_addr        output buffer address, pix*OUTPUT_CHANNEL + oc
//   out_data        unit result captured for the write
// -----------------------------------------------------------------------------
module pconv_ctrl #(
  parameter int N              = 16,
  parameter int INPUT_CHANNEL  = 3,
  parameter int OUTPUT_CHANNEL = 8,
  parameter int INPUT_SIZE     = 28,
  localparam int PIX = INPUT_SIZE * INPUT_SIZE,
  localparam int PA  = (PIX > 1) ? $clog2(PIX) : 1,
  localparam int WA  = (OUTPUT_CHANNEL > 1) ? $clog2(OUTPUT_CHANNEL) : 1,
  localparam int OA  = ((PIX * OUTPUT_CHANNEL) > 1) ? $clog2(PIX * OUTPUT_CHANNEL) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [PA-1:0]              pix_addr,
  input  logic [INPUT_CHANNEL*N-1:0] pix_din,
  output logic [WA-1:0]              w_addr,
  input  logic [INPUT_CHANNEL*N-1:0] w_din,
  input  logic [31:0]                bias_din,
  input  logic [4:0]                 shift_din,
  output logic                       u_ce,
  output logic                       u_input_vld,
  output logic [INPUT_CHANNEL*N-1:0] u_input_din,
  output logic [INPUT_CHANNEL*N-1:0] u_weight_din,
  output logic [31:0]                u_bias,
  output logic [4:0]                 u_shift,
  input  logic [N-1:0]               u_dout,
  input  logic                       u_dout_vld,
  output logic                       out_we,
  output logic [OA-1:0]              out_addr,
  output logic [N-1:0]               out_data
);

  localparam logic [PA-1:0] LAST_PIX = PA'(PIX - 1);
  localparam logic [WA-1:0] LAST_OC  = WA'(OUTPUT_CHANNEL - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Loop counters and the running output index.
  logic [PA-1:0] r_pix;
  logic [WA-1:0] r_oc;
  logic [OA-1:0] r_out_idx;

  // Counter values after the WRITE of the current result.
  logic [PA-1:0] w_pix_upd;
  logic [WA-1:0] w_oc_upd;
  logic          w_last;

  // Registered outputs.
  logic          r_busy;
  logic          r_done;
  logic          r_u_ce;
  logic          r_u_input_vld;
  logic          r_out_we;
  logic [PA-1:0] r_pix_addr;
  logic [WA-1:0] r_w_addr;
  logic [31:0]   r_u_bias;
  logic [4:0]    r_u_shift;
  logic [OA-1:0] r_out_addr;
  logic [N-1:0]  r_out_data;

  assign w_last = (r_pix == LAST_PIX) && (r_oc == LAST_OC);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_FETCH;
      S_FETCH: w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (u_dout_vld) w_state_next = S_WRITE;
      S_WRITE: w_state_next = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output channel is the inner loop; both counters wrap to 0 after the last
  // result so the next layer starts from the origin without extra clearing.
  always_comb begin
    w_pix_upd = r_pix;
    w_oc_upd  = r_oc;
    if (r_oc == LAST_OC) begin
      w_oc_upd  = '0;
      w_pix_upd = w_last ? '0 : r_pix + PA'(1);
    end else begin
      w_oc_upd  = r_oc + WA'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State register and control outputs
  // ---------------------------------------------------------------------------
  // Control outputs are decoded from the next state and registered, so they
  // line up with r_state and never glitch on state-encoding transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_u_ce        <= 1'b0;
      r_u_input_vld <= 1'b0;
      r_out_we      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_busy        <= (w_state_next != S_IDLE);
      r_done        <= (w_state_next == S_DONE);
      r_u_ce        <= (w_state_next != S_IDLE) && (w_state_next != S_DONE);
      r_u_input_vld <= (w_state_next == S_ISSUE);
      r_out_we      <= (w_state_next == S_WRITE);
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, memory addresses and write-back registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix      <= '0;
      r_oc       <= '0;
      r_out_idx  <= '0;
      r_pix_addr <= '0;
      r_w_addr   <= '0;
      r_u_bias   <= '0;
      r_u_shift  <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      // Addresses are presented during FETCH and then held, so the memories
      // may be read on either FETCH or LOAD without a change of address.
      if (w_state_next == S_FETCH) begin
        r_pix_addr <= (r_state == S_WRITE) ? w_pix_upd : r_pix;
        r_w_addr   <= (r_state == S_WRITE) ? w_oc_upd  : r_oc;
      end

      if (r_state == S_LOAD) begin
        r_u_bias  <= bias_din;
        r_u_shift <= shift_din;
      end

      // r_out_idx steps once per result in the same oc-inner/pix-outer order,
      // so it always equals pix*OUTPUT_CHANNEL + oc without a multiplier.
      if ((r_state == S_WAIT) && u_dout_vld) begin
        r_out_data <= u_dout;
        r_out_addr <= r_out_idx;
      end

      if (r_state == S_WRITE) begin
        r_pix     <= w_pix_upd;
        r_oc      <= w_oc_upd;
        r_out_idx <= w_last ? '0 : r_out_idx + OA'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane operand registers
  // ---------------------------------------------------------------------------
  // Lanes are latched during LOAD, the cycle in which the one-cycle-latency
  // memories return data for the address set up in FETCH.
  genvar gi;
  generate
    for (gi = 0; gi < INPUT_CHANNEL; gi++) begin : g_lane
      logic [N-1:0] r_in_lane;
      logic [N-1:0] r_wt_lane;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_in_lane <= '0;
          r_wt_lane <= '0;
        end else if (r_state == S_LOAD) begin
          r_in_lane <= pix_din[gi*N +: N];
          r_wt_lane <= w_din[gi*N +: N];
        end
      end

      assign u_input_din[gi*N +: N]  = r_in_lane;
      assign u_weight_din[gi*N +: N] = r_wt_lane;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign busy        = r_busy;
  assign done        = r_done;
  assign pix_addr    = r_pix_addr;
  assign w_addr      = r_w_addr;
  assign u_ce        = r_u_ce;
  assign u_input_vld = r_u_input_vld;
  assign u_bias      = r_u_bias;
  assign u_shift     = r_u_shift;
  assign out_we      = r_out_we;
  assign out_addr    = r_out_addr;
  assign out_data    = r_out_data;

endmodule

// File: tb/tb_pconv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pconv_ctrl
//   Directed bench for pconv_ctrl with a 2x2 map, 3 input channels and 2 output
//   channels. Input/weight memories are modelled with one-cycle read latency,
//   and the convolution unit is a behavioural model with programmable latency
//   (dot product + bias, arithmetic shift, ReLU).
// -----------------------------------------------------------------------------
module tb_pconv_ctrl;

  localparam int N  = 16;
  localparam int IC = 3;
  localparam int OC = 2;
  localparam int SZ = 2;
  localparam int PA = 2;
  localparam int WA = 1;
  localparam int OA = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done;
  logic [PA-1:0]     pix_addr;
  logic [IC*N-1:0]   pix_din = '0;
  logic [WA-1:0]     w_addr;
  logic [IC*N-1:0]   w_din = '0;
  logic [31:0]       bias_din = '0;
  logic [4:0]        shift_din = '0;
  logic              u_ce, u_input_vld;
  logic [IC*N-1:0]   u_input_din, u_weight_din;
  logic [31:0]       u_bias;
  logic [4:0]        u_shift;
  logic [N-1:0]      u_dout;
  logic              u_dout_vld;
  logic              out_we;
  logic [OA-1:0]     out_addr;
  logic [N-1:0]      out_data;

  int checks = 0;
  int errors = 0;

  pconv_ctrl #(
    .N(N), .INPUT_CHANNEL(IC), .OUTPUT_CHANNEL(OC), .INPUT_SIZE(SZ)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .pix_addr(pix_addr), .pix_din(pix_din), .w_addr(w_addr), .w_din(w_din),
    .bias_din(bias_din), .shift_din(shift_din), .u_ce(u_ce),
    .u_input_vld(u_input_vld), .u_input_din(u_input_din),
    .u_weight_din(u_weight_din), .u_bias(u_bias), .u_shift(u_shift),
    .u_dout(u_dout), .u_dout_vld(u_dout_vld), .out_we(out_we),
    .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Memories (one-cycle read latency)
  logic [IC*N-1:0] pixmem   [4];
  logic [IC*N-1:0] wmem     [2];
  logic [31:0]     biasmem  [2];
  logic [4:0]      shiftmem [2];

  always @(posedge clk) begin
    pix_din   <= pixmem[pix_addr];
    w_din     <= wmem[w_addr];
    bias_din  <= biasmem[w_addr];
    shift_din <= shiftmem[w_addr];
  end

  // Behavioural convolution unit
  int          lat = 1;
  bit          spur_en = 1'b0;
  int          cnt;
  logic [N-1:0] res;
  bit          sp;

  function automatic logic [N-1:0] unit_calc();
    longint acc;
    acc = longint'($signed(u_bias));
    for (int i = 0; i < IC; i++)
      acc += longint'($signed(u_input_din[i*N +: N])) * longint'($signed(u_weight_din[i*N +: N]));
    acc = acc >>> u_shift;
    if (acc < 0) return '0;
    return acc[N-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_dout_vld <= 1'b0;
      u_dout     <= '0;
      cnt        <= 0;
      res        <= '0;
      sp         <= 1'b0;
    end else begin
      u_dout_vld <= 1'b0;
      if (u_input_vld) begin
        if (lat <= 1) begin
          u_dout_vld <= 1'b1;
          u_dout     <= unit_calc();
        end else begin
          cnt <= lat - 1;
          res <= unit_calc();
        end
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          u_dout_vld <= 1'b1;
          u_dout     <= res;
        end
      end
      // Spurious valid with junk data in the two cycles after each write
      // (the FETCH and LOAD of the next result).
      if (spur_en && out_we) begin
        u_dout_vld <= 1'b1;
        u_dout     <= 16'h7777;
        sp         <= 1'b1;
      end else if (sp) begin
        u_dout_vld <= 1'b1;
        u_dout     <= 16'h7777;
        sp         <= 1'b0;
      end
    end
  end

  // Write / done monitor
  int          cyc = 0;
  int          done_cnt = 0;
  int          wr_addr [$];
  int          wr_data [$];
  int          wr_cyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_we) begin
      wr_addr.push_back(int'(out_addr));
      wr_data.push_back(int'(out_data));
      wr_cyc.push_back(cyc);
      $display("WR cyc=%0d addr=%0d data=%0h", cyc, out_addr, out_data);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      $display("DONE cyc=%0d", cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input string tag);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy_after_start"}, {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done(input string tag, input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, {63'd0, ok}, 64'd1);
  endtask

  task automatic check_layer(input string tag, input int base, input int exp_data, input int exp_gap);
    int n;
    n = wr_addr.size() - base;
    chk({tag, "_wr_count"}, 64'(n), 64'd8);
    if (n > 8) n = 8;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(wr_addr[base+i]), 64'(i));
      chk($sformatf("%s_data%0d", tag, i), 64'(wr_data[base+i]), 64'(exp_data));
      if (i > 0)
        chk($sformatf("%s_gap%0d", tag, i), 64'(wr_cyc[base+i] - wr_cyc[base+i-1]), 64'(exp_gap));
    end
  endtask

  initial begin
    int base;
    int dbase;

    for (int p = 0; p < 4; p++) pixmem[p] = {16'd768, 16'd512, 16'd256};
    for (int o = 0; o < 2; o++) begin
      wmem[o]     = {16'd256, 16'd256, 16'd256};
      biasmem[o]  = 32'd0;
      shiftmem[o] = 5'd8;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",     {63'd0, busy},   64'd0);
    chk("rst_done",     {63'd0, done},   64'd0);
    chk("rst_u_ce",     {63'd0, u_ce},   64'd0);
    chk("rst_out_we",   {63'd0, out_we}, 64'd0);
    chk("rst_pix_addr", 64'(pix_addr),   64'd0);
    chk("rst_out_addr", 64'(out_addr),   64'd0);
    chk("rst_u_bias",   64'(u_bias),     64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: latency 1, result 6<<8 at addresses 0..7, gap 5
    lat = 1;
    base = wr_addr.size(); dbase = done_cnt;
    launch("t1");
    wait_done("t1", 200);
    @(negedge clk);
    chk("t1_busy_after_done", {63'd0, busy}, 64'd0);
    chk("t1_u_shift", 64'(u_shift), 64'd8);
    repeat (10) @(negedge clk);
    check_layer("t1", base, 16'h0600, 5);
    chk("t1_done_count", 64'(done_cnt - dbase), 64'd1);

    // T2 + T5a: latency 5, start pulsed mid-layer is ignored
    lat = 5;
    base = wr_addr.size(); dbase = done_cnt;
    launch("t2");
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t2", 300);
    repeat (20) @(negedge clk);
    check_layer("t2", base, 16'h0600, 9);
    chk("t2_done_count", 64'(done_cnt - dbase), 64'd1);
    chk("t2_idle_busy", {63'd0, busy}, 64'd0);

    // T3: negative weights clamp to 0 in the unit
    lat = 2;
    for (int o = 0; o < 2; o++) wmem[o] = {16'hFF00, 16'hFF00, 16'hFF00};
    base = wr_addr.size(); dbase = done_cnt;
    launch("t3");
    wait_done("t3", 200);
    repeat (10) @(negedge clk);
    check_layer("t3", base, 0, 6);
    for (int o = 0; o < 2; o++) wmem[o] = {16'd256, 16'd256, 16'd256};

    // T6: spurious valid in FETCH/LOAD is ignored
    lat = 3;
    spur_en = 1'b1;
    base = wr_addr.size(); dbase = done_cnt;
    launch("t6");
    wait_done("t6", 200);
    repeat (10) @(negedge clk);
    spur_en = 1'b0;
    check_layer("t6", base, 16'h0600, 7);
    chk("t6_done_count", 64'(done_cnt - dbase), 64'd1);

    // T4: asynchronous reset after the 3rd write, then full restart
    lat = 1;
    base = wr_addr.size(); dbase = done_cnt;
    launch("t4");
    begin
      bit got3;
      got3 = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk); #1;
        if (wr_addr.size() >= base + 3) begin got3 = 1'b1; break; end
      end
      chk("t4_third_write_seen", {63'd0, got3}, 64'd1);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("t4_rst_busy",     {63'd0, busy},        64'd0);
    chk("t4_rst_out_we",   {63'd0, out_we},      64'd0);
    chk("t4_rst_u_ce",     {63'd0, u_ce},        64'd0);
    chk("t4_rst_pix_addr", 64'(pix_addr),        64'd0);
    chk("t4_rst_w_addr",   64'(w_addr),          64'd0);
    chk("t4_rst_out_addr", 64'(out_addr),        64'd0);
    chk("t4_rst_out_data", 64'(out_data),        64'd0);
    chk("t4_rst_u_in",     64'(u_input_din),     64'd0);
    chk("t4_rst_u_shift",  64'(u_shift),         64'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_writes_before_restart", 64'(wr_addr.size() - base), 64'd3);
    chk("t4_no_done", 64'(done_cnt - dbase), 64'd0);
    chk("t4_idle_busy", {63'd0, busy}, 64'd0);
    base = wr_addr.size();
    launch("t4r");
    wait_done("t4r", 200);
    repeat (10) @(negedge clk);
    check_layer("t4r", base, 16'h0600, 5);
    chk("t4r_done_count", 64'(done_cnt - dbase), 64'd1);

    // T5b: start held high relaunches the cycle after DONE
    base = wr_addr.size(); dbase = done_cnt;
    @(negedge clk); start = 1'b1;
    wait_done("t5a", 200);
    @(negedge clk);
    chk("t5_idle_gap_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("t5_relaunch_busy", {63'd0, busy}, 64'd1);
    start = 1'b0;
    wait_done("t5b", 200);
    repeat (10) @(negedge clk);
    chk("t5_wr_count", 64'(wr_addr.size() - base), 64'd16);
    check_layer("t5_second", base + 8, 16'h0600, 5);
    chk("t5_done_count", 64'(done_cnt - dbase), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
